// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and full/empty flags.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_en,
  input  logic                  r_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wptr_reg;
  logic [AW:0]           rptr_reg;
  logic [DATA_WIDTH-1:0] data_out_reg;
  logic                  wr_accept;
  logic                  rd_accept;

  // Flags depend only on pointer registers, never on the request inputs.
  assign empty = (wptr_reg == rptr_reg);
  assign full  = (wptr_reg[AW-1:0] == rptr_reg[AW-1:0]) &&
                 (wptr_reg[AW] != rptr_reg[AW]);

  assign wr_accept = w_en && !full;
  assign rd_accept = r_en && !empty;

  // Storage is left unreset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wptr_reg[AW-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_reg     <= '0;
      rptr_reg     <= '0;
      data_out_reg <= '0;
    end else begin
      if (wr_accept) begin
        wptr_reg <= wptr_reg + (AW+1)'(1);
      end
      if (rd_accept) begin
        data_out_reg <= mem[rptr_reg[AW-1:0]];
        rptr_reg     <= rptr_reg + (AW+1)'(1);
      end
    end
  end

  assign data_out = data_out_reg;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: vector table for steady-state traffic plus
// hand-written sequences for reset behaviour.
module tb_sync_fifo;

  logic       clk;
  logic       rst_n;
  logic       w_en;
  logic       r_en;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full;
  logic       empty;

  int n_checks = 0;
  int n_fail   = 0;

  sync_fifo #(.DATA_WIDTH(8), .DEPTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .w_en     (w_en),
    .r_en     (r_en),
    .data_in  (data_in),
    .data_out (data_out),
    .full     (full),
    .empty    (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       w;
    logic       r;
    logic [7:0] din;
    logic [7:0] exp_dout;
    logic       exp_full;
    logic       exp_empty;
  } vec_t;

  vec_t vecs [160];
  int   n_vec = 0;

  task automatic add(input logic w, input logic r, input logic [7:0] din,
                     input logic [7:0] dout, input logic f, input logic e);
    vecs[n_vec].w         = w;
    vecs[n_vec].r         = r;
    vecs[n_vec].din       = din;
    vecs[n_vec].exp_dout  = dout;
    vecs[n_vec].exp_full  = f;
    vecs[n_vec].exp_empty = e;
    n_vec++;
  endtask

  task automatic check(input string name, input int idx,
                       input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int idx,
                           input logic [7:0] dout, input logic f, input logic e);
    check({tag, "_data_out"}, idx, data_out, dout);
    check({tag, "_full"}, idx, {7'd0, full}, {7'd0, f});
    check({tag, "_empty"}, idx, {7'd0, empty}, {7'd0, e});
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] last;

    // ---------------- reset held with random requests ----------------
    rst_n = 1'b0;
    w_en = 1'b0; r_en = 1'b0; data_in = 8'd0;
    #2;
    for (int i = 0; i < 5; i++) begin
      w_en    = 1'($urandom_range(0, 1));
      r_en    = 1'($urandom_range(0, 1));
      data_in = 8'($urandom_range(0, 255));
      check_all("reset_hold", i, 8'd0, 1'b0, 1'b1);
      $display("reset_hold %0d: w=%0b r=%0b dout=%0d full=%0b empty=%0b",
               i, w_en, r_en, data_out, full, empty);
      #5;
    end
    @(negedge clk);
    w_en = 1'b0; r_en = 1'b0; data_in = 8'd0;
    rst_n = 1'b1;

    // ---------------- build vector table ----------------
    // basic order
    add(1, 0, 10, 0, 0, 0);
    add(1, 0, 20, 0, 0, 0);
    add(1, 0, 30, 0, 0, 0);
    add(1, 0, 40, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 10, 0, 0);
    add(0, 1, 0, 20, 0, 0);
    add(0, 1, 0, 30, 0, 0);
    add(0, 1, 0, 40, 0, 1);
    add(0, 1, 0, 40, 0, 1);
    // fill to full, overflow write dropped, drain
    for (int k = 1; k <= 8; k++) add(1, 0, 8'(k), 40, k == 8, 0);
    add(1, 0, 99, 40, 1, 0);
    for (int k = 1; k <= 8; k++) add(0, 1, 0, 8'(k), 0, k == 8);
    add(0, 1, 0, 8, 0, 1);
    // wrap-around: three rounds of six writes then six reads
    v = 8'd100;
    for (int rnd = 0; rnd < 3; rnd++) begin
      last = (rnd == 0) ? 8'd8 : 8'(v - 1);
      for (int k = 0; k < 6; k++) add(1, 0, 8'(v + k), last, 0, 0);
      for (int k = 0; k < 6; k++) add(0, 1, 0, 8'(v + k), 0, k == 5);
      v = 8'(v + 6);
    end
    // both requests on empty: write only, data_out keeps 117
    add(1, 1, 50, 117, 0, 0);
    add(1, 0, 51, 117, 0, 0);
    add(1, 0, 52, 117, 0, 0);
    add(1, 0, 53, 117, 0, 0);
    // half full, both requests: occupancy constant, order preserved
    for (int k = 0; k < 4; k++) add(1, 1, 8'(60 + k), 8'(50 + k), 0, 0);
    for (int k = 0; k < 4; k++) add(1, 0, 8'(64 + k), 53, k == 3, 0);
    // both requests on full: read only, write of 70 dropped
    add(1, 1, 70, 60, 0, 0);
    for (int k = 1; k <= 7; k++) add(0, 1, 0, 8'(60 + k), 0, k == 7);
    add(0, 1, 0, 67, 0, 1);

    // ---------------- apply table ----------------
    for (int i = 0; i < n_vec; i++) begin
      w_en    = vecs[i].w;
      r_en    = vecs[i].r;
      data_in = vecs[i].din;
      @(posedge clk);
      #1;
      check_all("vec", i, vecs[i].exp_dout, vecs[i].exp_full, vecs[i].exp_empty);
      $display("vec %0d: w=%0b r=%0b din=%0d -> dout=%0d full=%0b empty=%0b",
               i, vecs[i].w, vecs[i].r, vecs[i].din, data_out, full, empty);
      @(negedge clk);
    end
    w_en = 1'b0; r_en = 1'b0;

    // ---------------- reset mid-stream ----------------
    for (int k = 0; k < 3; k++) begin
      w_en = 1'b1; data_in = 8'(200 + k);
      @(posedge clk); #1;
      @(negedge clk);
    end
    w_en = 1'b0;
    r_en = 1'b1;
    @(posedge clk); #1;
    check_all("pre_reset_read", 0, 8'd200, 1'b0, 1'b0);
    $display("pre_reset_read: dout=%0d empty=%0b", data_out, empty);
    r_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_reset", 0, 8'd0, 1'b0, 1'b1);
    $display("async_reset: dout=%0d full=%0b empty=%0b", data_out, full, empty);
    @(negedge clk);
    rst_n = 1'b1;
    r_en  = 1'b1;
    @(posedge clk); #1;
    check_all("read_after_reset", 0, 8'd0, 1'b0, 1'b1);
    $display("read_after_reset: dout=%0d full=%0b empty=%0b", data_out, full, empty);
    @(negedge clk);
    r_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
